dw2_23_calc: RTL
================

Name: dw2_23_calc

Overview:
Computes the delta weight for w2_23 in the backpropagation network: dw2_23 = -(ETA × delta3_3 × a2_2), all values Q6.10 signed.
- Sits directly upstream of the w2_23 weight register.
- Drives that register's dw2_23 and select_update inputs.
- Uses one serial shift-add multiplier twice, instead of two parallel DSP multipliers, to save area.

Parameters:
ETA, 16'sd512, learning rate, Q6.10 signed (default 0.5); must be ≥ 0.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
delta3_3  in  16  output-layer error term, Q6.10 signed; sampled on the accepting edge.
a2_2  in  16  hidden-neuron activation, Q6.10 signed; sampled on the accepting edge.
dw2_23  out  16  delta weight, Q6.10 signed; registered and held until the next result.
select_update  out  1  one-cycle pulse when dw2_23 is new; wires to the weight register's select_update.
busy  out  1  high while a computation is in progress.

Behaviour:
- Reset (synchronous, highest priority at any time, including mid-operation):
  - dw2_23 = 0, select_update = 0, busy = 0, state = IDLE.
  - Iteration counter and internal operands cleared.
- States: IDLE → MUL1 → NORM1 → MUL2 → NORM2 → IDLE.
- IDLE, start = 1 at edge T0:
  - Latch sign1 = sign(delta3_3) XOR sign(a2_2).
  - Latch 17-bit magnitudes |delta3_3| and |a2_2| (|−32768| = 32768, no overflow).
  - busy ← 1; go to MUL1.
- MUL1: edges T1..T16, one shift-add step per edge (16 iterations), giving a 34-bit unsigned product.
- NORM1, edge T17:
  - m = (product + 512) >> 10 (round half away from zero in the magnitude domain).
  - Saturate: m ≤ 32767 if sign1 = 0, m ≤ 32768 if sign1 = 1.
  - Store p1 = signed(m, sign1).
  - Load the multiplier with |p1| and |ETA|; sign2 = sign(p1) XOR sign(ETA).
- MUL2: edges T18..T33.
- NORM2, edge T34:
  - Round and saturate as in NORM1 → p2.
  - dw2_23 ← saturate(−p2); −(−32768) → 32767.
  - select_update ← 1 and busy ← 0 on the same edge; go to IDLE.
- select_update is high for exactly one cycle (T34→T35), then 0.
- Latency: start-accept edge to result edge = 34 clocks. Throughput: one result per 35 clocks.
- start while busy: ignored, with no effect on the operation in flight.
- start high in the select_update cycle: accepted at T35 (back-to-back operation allowed).
- Zero operand: result is exactly 0; select_update still pulses.
- Inputs are not required to stay stable after the accepting edge.

Decomposition:
- Shared package nn_fixed_pkg:
  - FRAC_BITS = 10, WORD = 16.
  - Q_MAX = 16'sh7FFF, Q_MIN = 16'sh8000, ROUND_HALF = 512.
  - State encoding constants.
  - Round-and-saturate helper function.
- One sub-module: seq_mul17u, an unsigned 17×17 serial shift-add multiplier.
  - Ports: load, a, b, done, p[33:0].
  - Fixed 16-cycle run.
  - Reset by the parent's reset.

Test Plan:
- Basic: delta3_3 = 0x0400 (1.0), a2_2 = 0x0200 (0.5), ETA = 512, pulse start → after 34 clocks dw2_23 = 0xFF00 (−0.25), select_update high exactly 1 cycle, busy falls on the same edge.
- Sign: delta3_3 = 0xFC00 (−1.0), a2_2 = 0x0400 → dw2_23 = 0x0200 (+0.5).
- Rounding: delta3_3 = 0x0001, a2_2 = 0x0200, ETA = 512 → p1 = 1, p2 = 1, dw2_23 = 0xFFFF.
- Saturation: ETA = 1024, delta3_3 = 0x7FFF, a2_2 = 0x7FFF → p1 clamps to 0x7FFF, dw2_23 = 0x8001.
- Protocol: start held high through an entire operation → exactly one result, then a new op starts at T35; start pulsed mid-op → ignored.
- Reset mid-op: assert reset at T10 → next edge dw2_23 = 0, busy = 0, no select_update pulse; a subsequent start produces a correct result after 34 clocks.

Source files
------------

// File: rtl/nn_fixed_pkg.sv
// rtl/nn_fixed_pkg.sv - Q6.10 fixed-point constants, FSM encoding and rounding helpers
package nn_fixed_pkg;
    localparam int FRAC_BITS  = 10;
    localparam int WORD       = 16;
    localparam int ROUND_HALF = 512;
    localparam logic signed [WORD-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [WORD-1:0] Q_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL1  = 3'd1,
        ST_NORM1 = 3'd2,
        ST_MUL2  = 3'd3,
        ST_NORM2 = 3'd4
    } state_t;

    // A negative result may reach |Q_MIN|, a positive one only Q_MAX.
    function automatic logic [16:0] round_sat(input logic [33:0] prod, input logic neg);
        logic [33:0] r;
        logic [16:0] lim;
        r   = (prod + 34'(ROUND_HALF)) >> FRAC_BITS;
        lim = neg ? {1'b0, Q_MIN} : {1'b0, Q_MAX};
        if (r > 34'(lim))
            return lim;
        return r[16:0];
    endfunction

    function automatic logic [16:0] mag16(input logic [WORD-1:0] x);
        if (x[WORD-1])
            return {1'b0, ~x} + 17'd1;
        return {1'b0, x};
    endfunction
endpackage

// File: rtl/seq_mul17u.sv
// rtl/seq_mul17u.sv - unsigned 17x17 serial shift-add multiplier, fixed 16-cycle run
module seq_mul17u (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [16:0] a,
    input  logic [16:0] b,
    output logic        done,
    output logic [33:0] p
);
    logic [33:0] mcand;
    logic [15:0] mplier;
    logic [3:0]  cnt;
    logic        run;

    // b[16] is only set for b = 32768, whose low bits are zero, so that
    // partial product is folded into the load and 16 steps suffice.
    always_ff @(posedge clk) begin
        if (reset) begin
            p      <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (load) begin
            p      <= b[16] ? {1'b0, a, 16'b0} : 34'd0;
            mcand  <= {17'b0, a};
            mplier <= b[15:0];
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            if (mplier[0])
                p <= p + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 4'd1;
            if (cnt == 4'd15)
                run <= 1'b0;
        end
    end

    assign done = run && (cnt == 4'd15);
endmodule

// File: rtl/dw2_23_calc.sv
// rtl/dw2_23_calc.sv - dw2_23 = -(ETA * delta3_3 * a2_2) in Q6.10 using one shared serial multiplier
module dw2_23_calc
    import nn_fixed_pkg::*;
#(
    parameter logic signed [15:0] ETA = 16'sd512
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [WORD-1:0] delta3_3,
    input  logic [WORD-1:0] a2_2,
    output logic [WORD-1:0] dw2_23,
    output logic            select_update,
    output logic            busy
);
    state_t      state, state_nxt;
    logic        sign1, sign2;
    logic        mul_load, mul_done;
    logic [16:0] mul_a, mul_b, m;
    logic [33:0] prod;

    seq_mul17u u_mul (
        .clk   (clk),
        .reset (reset),
        .load  (mul_load),
        .a     (mul_a),
        .b     (mul_b),
        .done  (mul_done),
        .p     (prod)
    );

    assign m = round_sat(prod, (state == ST_NORM1) ? sign1 : sign2);

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_MUL1;
            ST_MUL1:  if (mul_done) state_nxt = ST_NORM1;
            ST_NORM1: state_nxt = ST_MUL2;
            ST_MUL2:  if (mul_done) state_nxt = ST_NORM2;
            ST_NORM2: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        mul_load = ((state == ST_IDLE) && start) || (state == ST_NORM1);
        mul_a    = (state == ST_IDLE) ? mag16(delta3_3) : m;
        mul_b    = (state == ST_IDLE) ? mag16(a2_2) : mag16(ETA);
    end

    // Negating p2: a negative p2 of -32768 flips to the positive limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign1         <= 1'b0;
            sign2         <= 1'b0;
            dw2_23        <= '0;
            select_update <= 1'b0;
        end else begin
            select_update <= 1'b0;
            if ((state == ST_IDLE) && start)
                sign1 <= delta3_3[WORD-1] ^ a2_2[WORD-1];
            if (state == ST_NORM1)
                sign2 <= (sign1 && (m != 17'd0)) ^ ETA[15];
            if (state == ST_NORM2) begin
                if (sign2)
                    dw2_23 <= (m == 17'd32768) ? Q_MAX : m[15:0];
                else
                    dw2_23 <= -m[15:0];
                select_update <= 1'b1;
            end
        end
    end
endmodule
